// File: rtl/path_player_pkg.sv
// Shared definitions for the path replay block: move encoding, FSM states and maze bounds.
package path_player_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int              MAZE_W   = 4;
  localparam logic [MAZE_W-1:0] MAZE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/path_player_step.sv
// Applies one move to (x, y); flags moves that would cross the 0/max edge instead of wrapping.
module step_unit
  import path_player_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               out_of_range
);

  localparam logic [COORD_W-1:0] CMAX = '1;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  always_comb begin
    nx           = x;
    ny           = y;
    out_of_range = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y == '0) out_of_range = 1'b1;
        else         ny = y - ONE;
      end
      DIR_RIGHT: begin
        if (x == CMAX) out_of_range = 1'b1;
        else           nx = x + ONE;
      end
      DIR_LEFT: begin
        if (x == '0) out_of_range = 1'b1;
        else         nx = x - ONE;
      end
      default: begin
        if (y == CMAX) out_of_range = 1'b1;
        else           ny = y + ONE;
      end
    endcase
  end

endmodule

// File: rtl/path_player.sv
// Replays the solver's move queue from (0,0), presenting each visited cell and
// reporting whether the walk ended cleanly at the far corner.
module path_player
  import path_player_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int MAX_STEPS   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         q_out,
  input  logic               finishq,
  output logic               rst_frontq,
  output logic               dequeue,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               pos_valid,
  output logic [7:0]         step_count,
  output logic               done,
  output logic               err
);

  localparam logic [COORD_W-1:0] CMAX      = '1;
  localparam int                 HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]      HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [7:0]         STEP_LIM  = 8'(MAX_STEPS);

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] x_reg, x_next, y_reg, y_next;
  logic [7:0]         step_reg, step_next;
  logic [HW-1:0]      hold_reg, hold_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               pos_valid_reg, pos_valid_next;
  logic               rfq_c, deq_c;

  logic [COORD_W-1:0] nx, ny;
  logic               out_of_range;

  step_unit #(.COORD_W(COORD_W)) u_step (
    .x            (x_reg),
    .y            (y_reg),
    .dir          (q_out),
    .nx           (nx),
    .ny           (ny),
    .out_of_range (out_of_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      step_reg      <= '0;
      hold_reg      <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      pos_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      step_reg      <= step_next;
      hold_reg      <= hold_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      pos_valid_reg <= pos_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    step_next      = step_reg;
    hold_next      = hold_reg;
    done_next      = done_reg;
    err_next       = err_reg;
    pos_valid_next = 1'b0;
    rfq_c          = 1'b0;
    deq_c          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_INIT;
      end
      ST_INIT: begin
        rfq_c          = 1'b1;
        x_next         = '0;
        y_next         = '0;
        step_next      = '0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        pos_valid_next = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_FETCH: begin
        // Termination causes are checked in priority order before any move is taken.
        if (finishq) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          err_next   = !((x_reg == CMAX) && (y_reg == CMAX));
        end else if (out_of_range || (step_reg == STEP_LIM)) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          deq_c          = 1'b1;
          x_next         = nx;
          y_next         = ny;
          step_next      = step_reg + 8'd1;
          pos_valid_next = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_HOLD;
            hold_next  = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_reg == '0) state_next = ST_FETCH;
        else                hold_next  = hold_reg - HW'(1);
      end
      ST_DONE: begin
        if (start) state_next = ST_INIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Queue strobes are masked while reset is held so an abort never disturbs the queue.
  assign rst_frontq = rfq_c & ~rst;
  assign dequeue    = deq_c & ~rst;
  assign x_o        = x_reg;
  assign y_o        = y_reg;
  assign pos_valid  = pos_valid_reg;
  assign step_count = step_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_path_player.sv
// Scoreboard bench for path_player: a main DUT with one hold cycle and a second with none.
module tb_path_player;

  localparam logic [1:0] MV_UP = 2'b00, MV_RT = 2'b01, MV_LF = 2'b10, MV_DN = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start0;
  logic [1:0] q1, q0;
  logic       fin1, fin0, rfq1, rfq0, deq1, deq0, pv1, pv0, done1, done0, err1, err0;
  logic [3:0] x1, y1, x0, y0;
  logic [7:0] sc1, sc0;

  logic [1:0] mem1 [64];
  logic [1:0] mem0 [64];
  int len1 = 0, len0 = 0, front1 = 0, front0 = 0;

  int checks = 0, errors = 0;
  int n_deq1 = 0, n_rfq1 = 0, n_pv1 = 0, n_deq0 = 0, n_rfq0 = 0, n_pv0 = 0;
  int cyc1 = 0, last1 = -1, cyc0 = 0, last0 = -1;
  logic [7:0] exp1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] e1, e0;
  int b_deq, b_rfq, b_pv;
  bit ok;

  path_player #(.COORD_W(4), .HOLD_CYCLES(1), .MAX_STEPS(255)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .q_out(q1), .finishq(fin1),
    .rst_frontq(rfq1), .dequeue(deq1), .x_o(x1), .y_o(y1), .pos_valid(pv1),
    .step_count(sc1), .done(done1), .err(err1)
  );

  path_player #(.COORD_W(4), .HOLD_CYCLES(0), .MAX_STEPS(255)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .q_out(q0), .finishq(fin0),
    .rst_frontq(rfq0), .dequeue(deq0), .x_o(x0), .y_o(y0), .pos_valid(pv0),
    .step_count(sc0), .done(done0), .err(err0)
  );

  // Queue models: the front pointer moves only on the DUT's strobes.
  always_ff @(posedge clk) begin
    if (rfq1) front1 <= 0; else if (deq1) front1 <= front1 + 1;
    if (rfq0) front0 <= 0; else if (deq0) front0 <= front0 + 1;
  end
  assign fin1 = (front1 >= len1);
  assign fin0 = (front0 >= len0);
  assign q1   = fin1 ? 2'b00 : mem1[front1[5:0]];
  assign q0   = fin0 ? 2'b00 : mem0[front0[5:0]];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push1(input int x, input int y);
    exp1.push_back({4'(x), 4'(y)});
  endtask

  task automatic push0(input int x, input int y);
    exp0.push_back({4'(x), 4'(y)});
  endtask

  // Monitors: count strobes, check step spacing, pop and compare presented cells.
  initial begin
    forever begin
      @(negedge clk);
      cyc1++;
      if (rfq1) begin n_rfq1++; last1 = -1; end
      if (deq1) begin
        n_deq1++;
        if (last1 >= 0) chk("deq_spacing", cyc1 - last1, 2);
        last1 = cyc1;
      end
      if (pv1) begin
        n_pv1++;
        if (exp1.size() == 0) chk("pos_unexpected", 1, 0);
        else begin
          e1 = exp1.pop_front();
          chk("pos_x", int'(x1), int'(e1[7:4]));
          chk("pos_y", int'(y1), int'(e1[3:0]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc0++;
      if (rfq0) begin n_rfq0++; last0 = -1; end
      if (deq0) begin
        n_deq0++;
        if (last0 >= 0) chk("deq_spacing0", cyc0 - last0, 1);
        last0 = cyc0;
      end
      if (pv0) begin
        n_pv0++;
        if (exp0.size() == 0) chk("pos_unexpected0", 1, 0);
        else begin
          e0 = exp0.pop_front();
          chk("pos_x0", int'(x0), int'(e0[7:4]));
          chk("pos_y0", int'(y0), int'(e0[3:0]));
        end
      end
    end
  end

  // Pulse start for one cycle and return in the first FETCH cycle.
  task automatic start_pulse1();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit which, output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which && done1) || (!which && done0)) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_timeout", int'(found), 1);
  endtask

  task automatic load_s1();
    for (int i = 0; i < 15; i++) mem1[i] = MV_RT;
    for (int i = 15; i < 30; i++) mem1[i] = MV_DN;
    len1 = 30;
  endtask

  task automatic push_s1();
    push1(0, 0);
    for (int i = 1; i < 16; i++) push1(i, 0);
    for (int j = 1; j < 16; j++) push1(15, j);
  endtask

  task automatic snap();
    b_deq = n_deq1; b_rfq = n_rfq1; b_pv = n_pv1;
  endtask

  task automatic check_s1_end(input string tag);
    chk({tag, "_x"}, int'(x1), 15);
    chk({tag, "_y"}, int'(y1), 15);
    chk({tag, "_steps"}, int'(sc1), 30);
    chk({tag, "_done"}, int'(done1), 1);
    chk({tag, "_err"}, int'(err1), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_x", int'(x1), 0);
    chk("rst_y", int'(y1), 0);
    chk("rst_steps", int'(sc1), 0);
    chk("rst_flags", int'({done1, err1, pv1}), 0);
    chk("rst_strobes", n_rfq1 + n_deq1 + n_rfq0 + n_deq0, 0);

    // 1: full diagonal-free walk to the far corner
    load_s1(); push_s1(); snap();
    start_pulse1();
    wait_done(1'b1, ok);
    check_s1_end("walk");
    chk("walk_rfq", n_rfq1 - b_rfq, 1);
    chk("walk_deq", n_deq1 - b_deq, 30);
    chk("walk_pv", n_pv1 - b_pv, 31);
    chk("walk_drain", exp1.size(), 0);

    // 2: empty queue
    len1 = 0; push1(0, 0); snap();
    start_pulse1();
    wait_done(1'b1, ok);
    chk("empty_err", int'(err1), 1);
    chk("empty_steps", int'(sc1), 0);
    chk("empty_rfq", n_rfq1 - b_rfq, 1);
    chk("empty_deq", n_deq1 - b_deq, 0);
    chk("empty_pv", n_pv1 - b_pv, 1);

    // 3: first move leaves the maze, twice in a row
    mem1[0] = MV_LF; len1 = 1;
    for (int r = 0; r < 2; r++) begin
      push1(0, 0); snap();
      start_pulse1();
      wait_done(1'b1, ok);
      chk("wrap_err", int'(err1), 1);
      chk("wrap_xy", int'({x1, y1}), 0);
      chk("wrap_deq", n_deq1 - b_deq, 0);
      chk("wrap_drain", exp1.size(), 0);
    end

    // 4: no hold cycles, short walk ending off-target
    mem0[0] = MV_RT; mem0[1] = MV_RT; mem0[2] = MV_DN; len0 = 3;
    push0(0, 0); push0(1, 0); push0(2, 0); push0(2, 1);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); #1;
    wait_done(1'b0, ok);
    chk("h0_steps", int'(sc0), 3);
    chk("h0_err", int'(err0), 1);
    chk("h0_xy", int'({x0, y0}), 8'h21);
    chk("h0_deq", n_deq0, 3);
    chk("h0_rfq", n_rfq0, 1);
    chk("h0_drain", exp0.size(), 0);

    // 5: reset after the fifth dequeue, then a clean replay
    load_s1();
    push1(0, 0);
    for (int i = 1; i < 6; i++) push1(i, 0);
    snap();
    start_pulse1();
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(negedge clk);
      if (deq1) k++;
    end
    chk("abort_reach5", k, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_xy", int'({x1, y1}), 0);
    chk("abort_steps", int'(sc1), 0);
    chk("abort_flags", int'({done1, err1, pv1, rfq1, deq1}), 0);
    repeat (6) @(negedge clk);
    chk("abort_deq", n_deq1 - b_deq, 5);
    chk("abort_drain", exp1.size(), 0);
    push_s1(); snap();
    start_pulse1();
    wait_done(1'b1, ok);
    check_s1_end("replay");
    chk("replay_deq", n_deq1 - b_deq, 30);
    chk("replay_drain", exp1.size(), 0);

    // 6: start held high through the walk, then restarts from DONE
    push_s1(); push_s1(); snap();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wait_done(1'b1, ok);
    check_s1_end("held");
    chk("held_rfq", n_rfq1 - b_rfq, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("held_rfq2", n_rfq1 - b_rfq, 2);
    chk("held_done_clr", int'(done1), 0);
    start1 = 1'b0;
    wait_done(1'b1, ok);
    check_s1_end("held2");
    chk("held_deq", n_deq1 - b_deq, 60);
    chk("held_drain", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/path_player.md
Name: path_player

Overview:
- Consumer end of the rat-solver path queue.
- After the solver finishes, this block rewinds the queue front, then dequeues the 2-bit move directions one at a time.
- It replays the walk from (0,0), presenting each visited cell as (x_o, y_o) with a valid pulse for display/checking logic.
- It flags completion, and flags an error if the walk leaves the 16x16 maze or does not end at (15,15).

Parameters:
- COORD_W, 4, coordinate width (maze is 2^COORD_W per side).
- HOLD_CYCLES, 1, idle cycles between consecutive steps (0 means one step per cycle).
- MAX_STEPS, 255, step limit; reaching it without finishq is an error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin replay; sampled in IDLE and DONE only
- q_out  in  2  direction at queue front (combinational from queue)
- finishq  in  1  queue front has passed the last entry
- rst_frontq  out  1  one-cycle pulse that rewinds the queue front
- dequeue  out  1  one-cycle pulse that advances the queue front
- x_o  out  COORD_W  current x
- y_o  out  COORD_W  current y
- pos_valid  out  1  one-cycle pulse when (x_o, y_o) holds a new cell
- step_count  out  8  moves performed
- done  out  1  replay finished (level, held)
- err  out  1  replay failed (level, held; valid when done=1)

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE
  - all outputs 0, x=y=0, step_count=0
  - no rst_frontq and no dequeue in the reset cycle or the following cycle
- Direction encoding (package constants):
  - 2'b00 UP: y-1
  - 2'b01 RIGHT: x+1
  - 2'b10 LEFT: x-1
  - 2'b11 DOWN: y+1
- States: IDLE, INIT, FETCH, HOLD, DONE.
- IDLE:
  - start=1 goes to INIT on the next edge.
- INIT (one cycle):
  - rst_frontq=1.
  - Registers x=y=0 and step_count=0; clears done and err.
  - pos_valid=1 in the following cycle, presenting (0,0).
  - Next state is FETCH.
- FETCH is evaluated combinationally on finishq and q_out. Exactly one of:
  - finishq=1: go to DONE, done<=1, err<=((x,y)!=(all ones, all ones)). No dequeue.
  - The move would wrap the coordinate (0-1 or max+1): go to DONE with done<=1, err<=1. No dequeue; x and y are unchanged.
  - step_count==MAX_STEPS: go to DONE with err<=1. No dequeue.
  - Otherwise:
    - dequeue=1 in this cycle.
    - x/y take the new value at the edge; step_count<=step_count+1.
    - pos_valid=1 in the next cycle.
    - Next state is HOLD, or FETCH if HOLD_CYCLES=0.
- HOLD:
  - A counter counts HOLD_CYCLES cycles, then returns to FETCH.
  - The counter reloads on every entry to HOLD.
- DONE:
  - Outputs are held.
  - start=1 goes to INIT, which clears done and err and replays from (0,0).
- Latency:
  - start to rst_frontq: 1 cycle.
  - Step spacing: HOLD_CYCLES+1 cycles.
  - Dequeue to updated x_o/y_o: same edge.
  - finishq is never sampled in the same cycle as the dequeue that produced it.
- Boundary conditions:
  - start in INIT, FETCH or HOLD is ignored.
  - Empty queue (finishq=1 at the first FETCH) gives done=1, err=1, step_count=0, zero dequeues.
  - rst mid-walk aborts immediately. Queue state is left as is; the next start rewinds it via rst_frontq.
  - Arithmetic is COORD_W-bit. Wrap is detected as the 0/max boundary before the update, so wrap never propagates into x_o/y_o.

Decomposition:
- Shared package holds:
  - direction constants DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN (same encoding as the solver's push_val)
  - state enum
  - the MAZE_MAX all-ones constant
- One sub-module, step_unit: combinational. Inputs are x, y and the direction; outputs are nx, ny and out_of_range.
- The FSM, hold counter and step counter stay in path_player.

Test Plan:
1. Queue model holds 15xRIGHT then 15xDOWN. Pulse start, HOLD_CYCLES=1.
   -> One rst_frontq pulse; 30 dequeue pulses spaced 2 cycles; 31 pos_valid pulses.
   -> Final x=15, y=15, step_count=30, done=1, err=0.
2. Queue empty (finishq=1). Pulse start.
   -> rst_frontq once, pos_valid once at (0,0), zero dequeues.
   -> done=1, err=1, step_count=0.
3. Queue {LEFT}. Pulse start.
   -> done=1, err=1, x=y=0, no dequeue; a second start replays identically.
4. Queue {RIGHT, RIGHT, DOWN} with HOLD_CYCLES=0.
   -> Dequeues on 3 consecutive cycles; pos sequence (0,0),(1,0),(2,0),(2,1).
   -> done=1, err=1 (not at 15,15).
5. Scenario 1 with rst asserted for one cycle after the 5th dequeue.
   -> Next cycle all outputs 0, state IDLE, no further dequeues.
   -> A new start replays from (0,0) and completes with err=0, step_count=30.
6. Keep start high through the entire scenario 1.
   -> Only one rst_frontq during the walk; after done, the still-high start restarts from INIT (second rst_frontq, done cleared).
